// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// One-cycle multiply, WIDTH-cycle restoring divide; stalls the pipeline until HI/LO are written.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_raw, b_raw, div_mag, rem, quo;
  logic             op_signed, neg_q, neg_r;

  logic             issue, is_mul, is_div, issue_signed;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] mul_a, mul_b, mul_p;
  logic [WIDTH:0]   shifted, trial;

  assign issue        = (state == S_IDLE) && start_i && !flush_i;
  assign is_mul       = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div       = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign issue_signed = (op_i == OP_MULT) || (op_i == OP_DIV);

  assign mag_a = (issue_signed && srca_i[WIDTH-1]) ? -srca_i : srca_i;
  assign mag_b = (issue_signed && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned
  // multiply equal to the signed product, so one multiplier serves both ops.
  assign mul_a = {{WIDTH{op_signed & a_raw[WIDTH-1]}}, a_raw};
  assign mul_b = {{WIDTH{op_signed & b_raw[WIDTH-1]}}, b_raw};
  assign mul_p = mul_a * mul_b;

  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, div_mag};

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (issue && is_mul) begin
          state_n = S_MUL;
          stall_o = 1'b1;
        end else if (issue && is_div) begin
          state_n = S_DIV;
          stall_o = 1'b1;
        end
      end
      S_MUL: begin
        stall_o = 1'b1;
        state_n = flush_i ? S_IDLE : S_DONE;
      end
      S_DIV: begin
        stall_o = 1'b1;
        if (flush_i)                           state_n = S_IDLE;
        else if (cnt == CNT_W'(WIDTH - 1))     state_n = S_FIX;
      end
      S_FIX: begin
        stall_o = 1'b1;
        state_n = flush_i ? S_IDLE : S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      a_raw     <= '0;
      b_raw     <= '0;
      div_mag   <= '0;
      rem       <= '0;
      quo       <= '0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi_o      <= '0;
      lo_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue && (is_mul || is_div)) begin
            a_raw     <= srca_i;
            b_raw     <= srcb_i;
            op_signed <= issue_signed;
            cnt       <= '0;
            rem       <= '0;
            quo       <= mag_a;
            div_mag   <= mag_b;
            neg_q     <= issue_signed & (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
            neg_r     <= issue_signed & srca_i[WIDTH-1];
          end
          if (issue && op_i == OP_MTHI) hi_o <= srca_i;
          if (issue && op_i == OP_MTLO) lo_o <= srca_i;
        end
        S_MUL: begin
          if (!flush_i) {hi_o, lo_o} <= mul_p;
        end
        S_DIV: begin
          // Restoring step: keep the trial remainder only when it did not go negative.
          cnt <= cnt + CNT_W'(1);
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        S_FIX: begin
          if (!flush_i) begin
            if (div_mag == '0) begin
              hi_o <= a_raw;
              lo_o <= '1;
            end else begin
              hi_o <= neg_r ? -rem : rem;
              lo_o <= neg_q ? -quo : quo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
